seq_detector: RTL



---
 rtl/seq_det_pkg.sv | 67 ++++++
 rtl/sat_counter.sv | 43 ++++
 rtl/seq_detector.sv | 91 +++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_det_pkg
//  Description : Shared helpers for seq_detector. Elaboration-time functions
//                build the KMP-style transition table of the pattern FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

    localparam int c_MAX_N = 16;

    // Bits needed to hold a matched-prefix length of 0..n.
    function automatic int state_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Longest proper prefix of the pattern that is also a suffix of the first k bits.
    // The pattern is stored MSB-first: bit n-1 is the first bit received.
    function automatic int fail_len(input logic [15:0] pattern, input int n, input int k);
        int   res;
        logic ok;
        res = 0;
        for (int l = 1; l < c_MAX_N; l++) begin
            if (l < k) begin
                ok = 1'b1;
                for (int i = 0; i < c_MAX_N; i++) begin
                    if (i < l) begin
                        if (pattern[n-1-i] != pattern[n-1-(k-l)-i]) ok = 1'b0;
                    end
                end
                if (ok) res = l;
            end
        end
        return res;
    endfunction

    // Next matched-prefix length after consuming bit b from prefix length s (s < n).
    function automatic int next_state(input logic [15:0] pattern, input int n,
                                      input int s, input logic b);
        int   res;
        int   t_idx;
        logic t_bit;
        logic ok;
        res = 0;
        if (s < n && b == pattern[n-1-s]) begin
            res = s + 1;
        end else begin
            // Longest prefix that is a suffix of (first s pattern bits, then b).
            for (int l = 1; l < c_MAX_N; l++) begin
                if (l <= s) begin
                    ok = 1'b1;
                    for (int i = 0; i < c_MAX_N; i++) begin
                        if (i < l) begin
                            t_idx = s + 1 - l + i;
                            t_bit = (t_idx == s) ? b : pattern[n-1-t_idx];
                            if (pattern[n-1-i] != t_bit) ok = 1'b0;
                        end
                    end
                    if (ok) res = l;
                end
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Saturating up-counter with synchronous clear. Holds at
//                all-ones instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] q_q;
    logic [CNT_W-1:0] q_d;

    // Next count: clear has priority, increment stops at the maximum value.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != {CNT_W{1'b1}})) begin
            q_d = q_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule
`default_nettype wire

// File: rtl/seq_detector.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detector
//  Description : Serial N-bit pattern detector (Moore + Mealy outputs) with
//                overlapping / non-overlapping matching. The optional
//                saturating match counter is built when SEQ_DET_COUNT_EN is
//                defined; otherwise match_count is tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_detector
    import seq_det_pkg::*;
#(
    parameter int           N       = 4,
    parameter logic [N-1:0] PATTERN = 4'b1011,
    parameter bit           OVERLAP = 1'b1,
    parameter int           CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   en,
    input  logic                   din,
    output logic                   match_mealy,
    output logic                   match_moore,
    output logic [$clog2(N+1)-1:0] state,
    output logic [CNT_W-1:0]       match_count
);

    localparam int          c_SW      = state_w(N);
    localparam logic [15:0] c_PAT     = 16'(PATTERN);
    // Prefix length a completed match falls back to before the next bit.
    localparam int          c_RESTART = OVERLAP ? fail_len(c_PAT, N, N) : 0;

    logic [c_SW-1:0] state_q;
    logic [c_SW-1:0] state_d;
    logic [c_SW-1:0] w_delta;
    logic            w_hit;
    logic [c_SW-1:0] w_nxt [0:N][0:1];

    // Transition table fixed at elaboration; state N re-enters via the restart prefix.
    for (genvar gs = 0; gs <= N; gs++) begin : g_state
        for (genvar gb = 0; gb < 2; gb++) begin : g_bit
            localparam int c_FROM = (gs == N) ? c_RESTART : gs;
            assign w_nxt[gs][gb] = c_SW'(next_state(c_PAT, N, c_FROM, (gb != 0)));
        end
    end

    // Next-state selection and Mealy output; clear overrides a coincident bit.
    always_comb begin
        w_delta = '0;
        for (int s = 0; s <= N; s++) begin
            if (state_q == c_SW'(s)) w_delta = w_nxt[s][din];
        end
        w_hit   = (w_delta == c_SW'(N));
        state_d = state_q;
        if (clear) begin
            state_d = '0;
        end else if (en) begin
            state_d = w_delta;
        end
        match_mealy = en & ~clear & w_hit;
    end

    // Matched-prefix length register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state       = state_q;
    assign match_moore = (state_q == c_SW'(N));

`ifdef SEQ_DET_COUNT_EN
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (match_mealy),
        .clr   (clear),
        .q     (match_count)
    );
`else
    assign match_count = '0;
`endif

endmodule
`default_nettype wire
